// File: rtl/ddr_stream_feeder_pkg.sv
// ddr_feed_pkg: FSM state type, counter width and LFSR tap table shared by the DDR lane sources.
package ddr_feed_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {IDLE, BURST, GAP, DONE} feed_state_t;

    // Fibonacci tap masks: 8 -> 7,5,4,3; 16 -> 15,13,12,10; 32 -> 31,21,1,0
    function automatic logic [31:0] lfsr_taps(int w);
        return w == 8 ? 32'h0000_00B8 : w == 32 ? 32'h8020_0003 : 32'h0000_B400;
    endfunction

endpackage

// File: rtl/ddr_stream_feeder_if.sv
// ddr_stream_feeder_if: run control inputs plus DDR word and status outputs of one lane feeder.
// master is the feeder side, slave is the consumer/controller side.
interface ddr_stream_feeder_if import ddr_feed_pkg::*; #(parameter int DATA_W = 16);

    logic              i_start;
    logic              i_pause;
    logic              o_ddr_wen;
    logic [DATA_W-1:0] o_ddr_data;
    logic              o_busy;
    logic              o_burst_done;
    logic [CNT_W-1:0]  o_word_cnt;
    logic [DATA_W-1:0] o_checksum;

    modport master (
        input  i_start, i_pause,
        output o_ddr_wen, o_ddr_data, o_busy, o_burst_done, o_word_cnt, o_checksum
    );

    modport slave (
        output i_start, i_pause,
        input  o_ddr_wen, o_ddr_data, o_busy, o_burst_done, o_word_cnt, o_checksum
    );

endinterface

// File: rtl/ddr_stream_feeder_lfsr_core.sv
// lfsr_core: shift-left Fibonacci LFSR with synchronous load; a zero SEED is replaced by 1.
module lfsr_core import ddr_feed_pkg::*; #(
    parameter int DATA_W = 16,
    parameter int SEED   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    output logic [DATA_W-1:0] state
);

    localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));
    localparam logic [DATA_W-1:0] INIT = SEED == 0 ? DATA_W'(1) : DATA_W'(SEED);

    always_ff @(posedge clk)
        if (rst || load) state <= INIT;
        else if (advance) state <= {state[DATA_W-2:0], ^(state & TAPS)};

endmodule

// File: rtl/ddr_stream_feeder.sv
// ddr_stream_feeder: per-lane burst/gap source of LFSR words for one DLA DDR input port.
// Define DDR_FEED_CHECKSUM_EN to build the running checksum; otherwise o_checksum is tied to 0.
module ddr_stream_feeder import ddr_feed_pkg::*; #(
    parameter int DATA_W     = 16,
    parameter int SEED       = 1,
    parameter int BURST_LEN  = 64,
    parameter int GAP_LEN    = 4,
    parameter int NUM_BURSTS = 0
) (
    input logic clk,
    input logic rst,
    ddr_stream_feeder_if.master bus
);

    feed_state_t st, ns;
    logic [CNT_W-1:0] beat, gap, bursts;
    logic [DATA_W-1:0] word;
    logic first, fin, done_n, gap_end, restart, emit, lfsr_load;

    // st is the state of the cycle whose registered outputs are currently visible
    assign first     = st == IDLE && bus.i_start;
    assign fin       = st == BURST && beat == CNT_W'(BURST_LEN);
    assign done_n    = fin && NUM_BURSTS != 0 && bursts + 32'd1 == CNT_W'(NUM_BURSTS);
    assign gap_end   = st == GAP && gap == CNT_W'(GAP_LEN);
    assign restart   = first || fin || gap_end;
    assign emit      = first || (!bus.i_pause && ((st == BURST && !(fin && ns != BURST)) || gap_end));
    assign lfsr_load = st == DONE || (st == IDLE && !bus.i_start);

    always_comb
        ns = st == IDLE  ? (bus.i_start ? BURST : IDLE)
           : st == BURST ? (fin ? (done_n ? DONE : GAP_LEN != 0 ? GAP : BURST) : BURST)
           : st == GAP   ? (gap_end ? BURST : GAP)
           : IDLE;

    lfsr_core #(.DATA_W(DATA_W), .SEED(SEED)) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (lfsr_load),
        .advance(emit),
        .state  (word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st               <= IDLE;
            beat             <= '0;
            gap              <= '0;
            bursts           <= '0;
            bus.o_ddr_wen    <= 1'b0;
            bus.o_ddr_data   <= '0;
            bus.o_busy       <= 1'b0;
            bus.o_burst_done <= 1'b0;
            bus.o_word_cnt   <= '0;
        end else begin
            st               <= ns;
            beat             <= emit ? (restart ? 32'd1 : beat + 32'd1) : (restart ? '0 : beat);
            gap              <= st == GAP ? gap + 32'd1 : 32'd1;
            bursts           <= first ? '0 : fin ? bursts + 32'd1 : bursts;
            bus.o_ddr_wen    <= emit;
            bus.o_ddr_data   <= emit ? word : bus.o_ddr_data;
            bus.o_busy       <= ns != IDLE;
            bus.o_burst_done <= ns == DONE;
            bus.o_word_cnt   <= emit ? (first ? '0 : bus.o_word_cnt) + 32'd1 : bus.o_word_cnt;
        end
    end

`ifdef DDR_FEED_CHECKSUM_EN
    always_ff @(posedge clk)
        if (rst) bus.o_checksum <= '0;
        else if (emit) bus.o_checksum <= (first ? '0 : bus.o_checksum) + word;
`else
    assign bus.o_checksum = '0;
`endif

endmodule

// File: tb/tb_ddr_stream_feeder.sv
// tb_ddr_stream_feeder: directed scenarios plus a randomized run checked against a burst-script model.
// Stimulus index c: inputs set before clock edge c, outputs sampled 1 time unit after it.
module tb_ddr_stream_feeder;

    localparam int A_BL = 4, A_GAP = 2, A_NB = 2;
    localparam int TK_FIRST = 0, TK_WORD = 1, TK_GAP = 2, TK_DONE = 3;
`ifdef DDR_FEED_CHECKSUM_EN
    localparam logic [15:0] EXP_CKS = 16'h00FF;
    localparam bit CKS_ON = 1'b1;
`else
    localparam logic [15:0] EXP_CKS = 16'h0000;
    localparam bit CKS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ddr_stream_feeder_if #(.DATA_W(16)) ia();
    ddr_stream_feeder_if #(.DATA_W(16)) ib();

    ddr_stream_feeder #(.DATA_W(16), .SEED(1), .BURST_LEN(A_BL), .GAP_LEN(A_GAP), .NUM_BURSTS(A_NB)) dut_a (
        .clk(clk), .rst(rst), .bus(ia)
    );

    ddr_stream_feeder #(.DATA_W(16), .SEED(0), .BURST_LEN(4), .GAP_LEN(0), .NUM_BURSTS(0)) dut_b (
        .clk(clk), .rst(rst), .bus(ib)
    );

    function automatic logic [15:0] lfsr_next(logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        ia.i_start = 1'b0;
        ia.i_pause = 1'b0;
        ib.i_start = 1'b0;
        ib.i_pause = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        n_run++; if (ia.o_ddr_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen got %b want 0", ia.o_ddr_wen); end
        n_run++; if (ia.o_ddr_data !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h want 0000", ia.o_ddr_data); end
        n_run++; if (ia.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", ia.o_busy); end
        n_run++; if (ia.o_burst_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", ia.o_burst_done); end
        n_run++; if (ia.o_word_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", ia.o_word_cnt); end
        n_run++; if (ia.o_checksum !== 16'h0) begin n_fail++; $display("FAIL reset_cks got %h want 0000", ia.o_checksum); end
    endtask

    // start at c=1 and optionally extra start pulses that must be ignored
    task automatic run_two_bursts(input string name, input int extra1, input int extra2, input int ncyc);
        logic exp_w;
        logic [15:0] exp_d;
        do_reset();
        for (int c = 1; c <= ncyc; c++) begin
            ia.i_start = (c == 1) || (c == extra1) || (c == extra2);
            tick();
            exp_w = (c <= 4) || (c >= 7 && c <= 10);
            exp_d = c <= 4 ? 16'(1 << (c - 1)) : c <= 6 ? 16'h0008 : c <= 10 ? 16'(1 << (c - 3)) : 16'h0080;
            n_run++;
            if ({ia.o_ddr_wen, ia.o_ddr_data, ia.o_burst_done, ia.o_busy} !== {exp_w, exp_d, c == 11, c <= 11}) begin
                n_fail++;
                $display("FAIL %s c%0d got wen=%b data=%h done=%b busy=%b want wen=%b data=%h done=%b busy=%b",
                         name, c, ia.o_ddr_wen, ia.o_ddr_data, ia.o_burst_done, ia.o_busy,
                         exp_w, exp_d, c == 11, c <= 11);
            end
        end
        ia.i_start = 1'b0;
        n_run++; if (ia.o_word_cnt !== 32'd8) begin n_fail++; $display("FAIL %s_cnt got %0d want 8", name, ia.o_word_cnt); end
        n_run++; if (ia.o_checksum !== EXP_CKS) begin n_fail++; $display("FAIL %s_cks got %h want %h", name, ia.o_checksum, EXP_CKS); end
    endtask

    task automatic test_basic;
        run_two_bursts("basic", 0, 0, 12);
    endtask

    task automatic test_start_ignored;
        run_two_bursts("start_ign", 4, 12, 14);
    endtask

    task automatic test_pause;
        logic exp_w;
        logic [15:0] exp_d;
        do_reset();
        for (int c = 1; c <= 7; c++) begin
            ia.i_start = (c == 1);
            ia.i_pause = (c == 2) || (c == 3);
            tick();
            exp_w = c == 1 || (c >= 4 && c <= 6);
            exp_d = c <= 3 ? 16'h0001 : c == 4 ? 16'h0002 : c == 5 ? 16'h0004 : 16'h0008;
            n_run++;
            if ({ia.o_ddr_wen, ia.o_ddr_data, ia.o_busy} !== {exp_w, exp_d, 1'b1}) begin
                n_fail++;
                $display("FAIL pause c%0d got wen=%b data=%h busy=%b want wen=%b data=%h busy=1",
                         c, ia.o_ddr_wen, ia.o_ddr_data, ia.o_busy, exp_w, exp_d);
            end
        end
        ia.i_start = 1'b0;
        ia.i_pause = 1'b0;
    endtask

    task automatic test_reset_midrun;
        do_reset();
        for (int c = 1; c <= 3; c++) begin
            ia.i_start = (c == 1);
            tick();
        end
        n_run++; if ({ia.o_ddr_wen, ia.o_ddr_data} !== {1'b1, 16'h0004}) begin
            n_fail++; $display("FAIL midrun_pre got wen=%b data=%h want wen=1 data=0004", ia.o_ddr_wen, ia.o_ddr_data);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_run++; if ({ia.o_ddr_wen, ia.o_busy, ia.o_word_cnt} !== {1'b0, 1'b0, 32'd0}) begin
            n_fail++; $display("FAIL midrun_rst got wen=%b busy=%b cnt=%0d want 0 0 0", ia.o_ddr_wen, ia.o_busy, ia.o_word_cnt);
        end
        ia.i_start = 1'b1;
        tick();
        ia.i_start = 1'b0;
        n_run++; if ({ia.o_ddr_wen, ia.o_ddr_data, ia.o_word_cnt} !== {1'b1, 16'h0001, 32'd1}) begin
            n_fail++; $display("FAIL midrun_restart got wen=%b data=%h cnt=%0d want wen=1 data=0001 cnt=1",
                               ia.o_ddr_wen, ia.o_ddr_data, ia.o_word_cnt);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] m;
        do_reset();
        m = 16'h0001;
        ib.i_start = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            ib.i_start = 1'b0;
            n_run++;
            if ({ib.o_ddr_wen, ib.o_burst_done, ib.o_busy, ib.o_ddr_data} !== {1'b1, 1'b0, 1'b1, m}) begin
                n_fail++;
                $display("FAIL b2b c%0d got wen=%b done=%b busy=%b data=%h want wen=1 done=0 busy=1 data=%h",
                         c, ib.o_ddr_wen, ib.o_burst_done, ib.o_busy, ib.o_ddr_data, m);
            end
            m = lfsr_next(m);
        end
        n_run++; if (ib.o_word_cnt !== 32'd100) begin n_fail++; $display("FAIL b2b_cnt got %0d want 100", ib.o_word_cnt); end
    endtask

    // Model: a started run is a script of cycle tokens; a WORD token waits while pause is seen.
    task automatic test_random;
        int q[$];
        int tok;
        bit r, s, p, pbusy, m_wen, m_busy, m_done;
        logic [15:0] m_lfsr, m_data, m_cks;
        logic [31:0] m_cnt;
        logic [66:0] got, exp;
        do_reset();
        pbusy = 0; m_lfsr = 16'h0001; m_data = '0; m_cks = '0; m_cnt = '0;
        for (int c = 1; c <= 4000; c++) begin
            r = $urandom_range(0, 299) == 0;
            s = $urandom_range(0, 7) == 0;
            p = $urandom_range(0, 3) == 0;
            rst = r;
            ia.i_start = s;
            ia.i_pause = p;
            tick();
            m_wen = 0; m_done = 0; m_busy = 0;
            if (r) begin
                q.delete(); m_data = '0; m_cks = '0; m_cnt = '0;
            end else begin
                if (!pbusy && s) begin
                    q.delete();
                    m_lfsr = 16'h0001; m_cnt = '0; m_cks = '0;
                    q.push_back(TK_FIRST);
                    repeat (A_BL - 1) q.push_back(TK_WORD);
                    for (int b = 2; b <= A_NB; b++) begin
                        repeat (A_GAP) q.push_back(TK_GAP);
                        repeat (A_BL) q.push_back(TK_WORD);
                    end
                    q.push_back(TK_DONE);
                end
                if (q.size() != 0) begin
                    m_busy = 1;
                    tok = q[0];
                    if (!(tok == TK_WORD && p)) begin
                        void'(q.pop_front());
                        if (tok == TK_DONE) m_done = 1;
                        if (tok == TK_FIRST || tok == TK_WORD) begin
                            m_wen = 1; m_data = m_lfsr; m_cnt = m_cnt + 1; m_cks = m_cks + m_lfsr;
                            m_lfsr = lfsr_next(m_lfsr);
                        end
                    end
                end
            end
            pbusy = m_busy;
            got = {ia.o_ddr_wen, ia.o_busy, ia.o_burst_done, ia.o_ddr_data, ia.o_word_cnt, ia.o_checksum};
            exp = {m_wen, m_busy, m_done, m_data, m_cnt, CKS_ON ? m_cks : 16'h0};
            n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random c%0d got {wen,busy,done,data,cnt,cks}=%h want %h", c, got, exp);
            end
        end
        rst = 1'b0;
        ia.i_start = 1'b0;
        ia.i_pause = 1'b0;
    endtask

    initial begin
        ia.i_start = 1'b0;
        ia.i_pause = 1'b0;
        ib.i_start = 1'b0;
        ib.i_pause = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_pause();
        test_start_ignored();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
